// File: rtl/flash_xip_pkg.sv
// Shared types and parameter-derived widths for the XIP line cache.
package flash_xip_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL_REQ,
    S_FILL_WAIT
  } state_t;

  function automatic int offBits(input int lineWords);
    return $clog2(lineWords);
  endfunction

  function automatic int idxBits(input int numLines);
    return $clog2(numLines);
  endfunction

  function automatic int tagBits(input int addrW, input int lineWords, input int numLines);
    return addrW - 2 - offBits(lineWords) - idxBits(numLines);
  endfunction

  // A one-word line has no offset field, but counters still need a bit.
  function automatic int cntBits(input int lineWords);
    return (offBits(lineWords) > 0) ? offBits(lineWords) : 1;
  endfunction

endpackage

// File: rtl/flash_xip_tag_array.sv
// Tag and valid storage for the XIP cache: combinational lookup,
// single-cycle clear of every line, and per-line set/clear.
module flash_xip_tag_array
  import flash_xip_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int TAG_W     = 17
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [idxBits(NUM_LINES)-1:0] i_lookupIdx,
  input  logic [TAG_W-1:0]              i_lookupTag,
  output logic                          o_hit,
  input  logic                          i_clearAll,
  input  logic                          i_clrEn,
  input  logic [idxBits(NUM_LINES)-1:0] i_clrIdx,
  input  logic                          i_setEn,
  input  logic [idxBits(NUM_LINES)-1:0] i_setIdx,
  input  logic [TAG_W-1:0]              i_setTag
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tags [NUM_LINES];

  // Clear-all dominates so an invalidate can never be undone by a fill finishing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else if (i_clearAll) begin
      r_valid <= '0;
    end else begin
      if (i_clrEn) r_valid[i_clrIdx] <= 1'b0;
      if (i_setEn) r_valid[i_setIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_setEn) r_tags[i_setIdx] <= i_setTag;
  end

  assign o_hit = r_valid[i_lookupIdx] && (r_tags[i_lookupIdx] == i_lookupTag);

endmodule

// File: rtl/flash_xip_cache.sv
// Blocking direct-mapped read-only line cache between the OBI XIP fetch port
// and the flash engine word-read interface, with invalidation and statistics.
module flash_xip_cache
  import flash_xip_pkg::*;
#(
  parameter int NUM_LINES  = 8,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       data_o,
  output logic              err_o,
  input  logic              invalidate_i,
  input  logic              clr_cnt_i,
  output logic              busy_o,
  output logic              eng_req_o,
  input  logic              eng_gnt_i,
  output logic [ADDR_W-1:0] eng_addr_o,
  input  logic              eng_ready_i,
  input  logic [31:0]       eng_data_i,
  input  logic              eng_error_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int OFF_W = offBits(LINE_WORDS);
  localparam int IDX_W = idxBits(NUM_LINES);
  localparam int TAG_W = tagBits(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam int CNT_W = cntBits(LINE_WORDS);

  state_t              r_state;
  state_t              w_nextState;
  logic [IDX_W-1:0]    w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [CNT_W-1:0]    w_offset;
  logic                w_hit;
  logic                w_rdHit;
  logic                w_rdMiss;
  logic                w_wrReq;
  logic                w_lastWord;
  logic                w_wordDone;
  logic                w_fillOk;
  logic                w_unusedAddr;
  logic [IDX_W-1:0]    r_index;
  logic [TAG_W-1:0]    r_tag;
  logic [CNT_W-1:0]    r_reqOff;
  logic [CNT_W-1:0]    r_fillCnt;
  logic [ADDR_W-1:0]   r_baseAddr;
  logic                r_sticky;
  logic                r_rvalid;
  logic                r_err;
  logic [31:0]         r_data;
  logic [31:0]         r_hitCnt;
  logic [31:0]         r_missCnt;
  logic [31:0]         r_dataArr [NUM_LINES][LINE_WORDS];

  generate
    if (OFF_W > 0) begin : g_off
      assign w_offset = addr_i[2 +: OFF_W];
    end else begin : g_noOff
      assign w_offset = '0;
    end
  endgenerate

  assign w_index      = addr_i[2+OFF_W +: IDX_W];
  assign w_tag        = addr_i[ADDR_W-1 -: TAG_W];
  assign w_unusedAddr = &{1'b0, addr_i[31:ADDR_W], addr_i[1:0]};

  assign w_rdHit    = gnt_o && !we_i && w_hit;
  assign w_rdMiss   = gnt_o && !we_i && !w_hit;
  assign w_wrReq    = gnt_o && we_i;
  assign w_lastWord = (r_fillCnt == CNT_W'(LINE_WORDS - 1));
  assign w_wordDone = (r_state == S_FILL_WAIT) && eng_ready_i && !eng_error_i;
  assign w_fillOk   = w_wordDone && w_lastWord;

  // Line being filled is invalidated up front so an aborted fill leaves no stale hit.
  flash_xip_tag_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_tagArray (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_lookupIdx (w_index),
    .i_lookupTag (w_tag),
    .o_hit       (w_hit),
    .i_clearAll  (invalidate_i),
    .i_clrEn     (w_rdMiss),
    .i_clrIdx    (w_index),
    .i_setEn     (w_fillOk && !r_sticky && !invalidate_i),
    .i_setIdx    (r_index),
    .i_setTag    (r_tag)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:      if (w_rdMiss)    w_nextState = S_FILL_REQ;
      S_FILL_REQ:  if (eng_gnt_i)   w_nextState = S_FILL_WAIT;
      S_FILL_WAIT: if (eng_ready_i) w_nextState = (eng_error_i || w_lastWord) ? S_IDLE : S_FILL_REQ;
      default:                      w_nextState = S_IDLE;
    endcase
  end

  // Grant is also masked by reset so nothing is accepted while the block is held.
  always_comb begin
    gnt_o      = req_i && (r_state == S_IDLE) && !invalidate_i && !rst_i;
    busy_o     = (r_state != S_IDLE);
    eng_req_o  = 1'b0;
    eng_addr_o = '0;
    if (r_state == S_FILL_REQ) begin
      eng_req_o  = 1'b1;
      eng_addr_o = r_baseAddr + (ADDR_W'(r_fillCnt) << 2);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_data     <= '0;
      r_fillCnt  <= '0;
      r_sticky   <= 1'b0;
      r_index    <= '0;
      r_tag      <= '0;
      r_reqOff   <= '0;
      r_baseAddr <= '0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_wrReq) begin
        r_rvalid <= 1'b1;
        r_err    <= 1'b1;
        r_data   <= '0;
      end
      if (w_rdHit) begin
        r_rvalid <= 1'b1;
        r_err    <= 1'b0;
        r_data   <= r_dataArr[w_index][w_offset];
      end
      if (w_rdMiss) begin
        r_index    <= w_index;
        r_tag      <= w_tag;
        r_reqOff   <= w_offset;
        r_fillCnt  <= '0;
        r_baseAddr <= {w_tag, w_index, {(OFF_W+2){1'b0}}};
      end
      if ((r_state == S_FILL_WAIT) && eng_ready_i) begin
        if (eng_error_i) begin
          r_rvalid  <= 1'b1;
          r_err     <= 1'b1;
          r_data    <= '0;
          r_fillCnt <= '0;
        end else begin
          r_fillCnt <= w_lastWord ? '0 : r_fillCnt + 1'b1;
          if (w_lastWord) begin
            r_rvalid <= 1'b1;
            r_err    <= 1'b0;
            r_data   <= (r_reqOff == r_fillCnt) ? eng_data_i : r_dataArr[r_index][r_reqOff];
          end
        end
      end
      if (w_nextState == S_IDLE)                      r_sticky <= 1'b0;
      else if (invalidate_i && (r_state != S_IDLE))   r_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wordDone) r_dataArr[r_index][r_fillCnt] <= eng_data_i;
  end

  // Counters saturate rather than wrap; a clear request beats a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else begin
      if (w_rdHit && (r_hitCnt != '1))   r_hitCnt  <= r_hitCnt + 1'b1;
      if (w_rdMiss && (r_missCnt != '1)) r_missCnt <= r_missCnt + 1'b1;
    end
  end

  assign rvalid_o   = r_rvalid;
  assign err_o      = r_err;
  assign data_o     = r_data;
  assign hit_cnt_o  = r_hitCnt;
  assign miss_cnt_o = r_missCnt;

endmodule

// File: doc/flash_xip_cache.md
# flash_xip_cache

Parametrised successor to the single-word hardware fetch path of the flash controller: a blocking, direct-mapped, read-only line cache between the OBI execute-in-place (XIP) fetch port and the flash engine's word-read operation interface. On a miss it fills a complete line, issuing LINE_WORDS word reads to the engine. It adds software invalidation after program/erase, error propagation, and hit/miss statistics. Engine ownership is arbitrated outside the block via `eng_gnt_i`.

## Interface
- NUM_LINES, 8: number of cache lines; power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥1.
- ADDR_W, 24: flash byte-address width; tag = ADDR_W − 2 − log2(LINE_WORDS) − log2(NUM_LINES) bits.
- clk_i  in  1  single clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  OBI request.
- we_i  in  1  OBI write enable; writes are illegal.
- addr_i  in  32  byte address; bits [ADDR_W-1:2] used.
- gnt_o  out  1  OBI grant.
- rvalid_o  out  1  response valid, one cycle per granted request.
- data_o  out  32  response data.
- err_o  out  1  response error, qualified by rvalid_o.
- invalidate_i  in  1  pulse; clears all valid bits.
- clr_cnt_i  in  1  pulse; zeroes both statistics counters.
- busy_o  out  1  high whenever state ≠ S_IDLE.
- eng_req_o  out  1  word-read request to engine.
- eng_gnt_i  in  1  engine accepts request this cycle.
- eng_addr_o  out  ADDR_W  word-aligned read address.
- eng_ready_i  in  1  engine read complete.
- eng_data_i  in  32  read data, valid with eng_ready_i.
- eng_error_i  in  1  read failed, valid with eng_ready_i.
- hit_cnt_o  out  32  saturating hit count.
- miss_cnt_o  out  32  saturating miss count.

## Operation
- Address split: offset = addr_i[2 +: log2 LINE_WORDS]; index = next log2 NUM_LINES bits; tag = the remaining bits up to ADDR_W-1.
- Storage: flop arrays for data, tag, and valid.
- `gnt_o = req_i && state==S_IDLE && !invalidate_i`.
- States:
  - S_IDLE → S_FILL_REQ on a granted read miss.
  - S_FILL_REQ → S_FILL_WAIT on `eng_req_o && eng_gnt_i`.
  - S_FILL_WAIT → S_FILL_REQ on `eng_ready_i` when words remain.
  - S_FILL_WAIT → S_IDLE on `eng_ready_i` for the last word or on `eng_error_i`; the response is issued on this transition.
- Granted write: no state change; the following cycle gives `rvalid_o=1`, `err_o=1`, `data_o=0`. Counters are unchanged.
- Hit: the following cycle gives `rvalid_o=1`, `err_o=0`, `data_o` = cached word. hit_cnt increments.
- Miss: miss_cnt increments. The line base address and requested offset are latched, and the fill counter is cleared.
  - `eng_addr_o` = base + 4·counter, held stable while eng_req_o is high.
  - eng_req_o falls the cycle after grant.
  - Each eng_ready_i writes the data word, and the counter increments; it wraps to 0 after LINE_WORDS−1.
- Fill completion: tag is written and valid is set. The response carries the requested word.
- eng_error_i on any word: fill aborts and the line is left invalid (its valid bit is cleared at miss start). Response is `err_o=1`, `data_o=0`.
- Invalidate during a fill: all valid bits clear immediately, and a sticky flag is set. The fill completes and responds normally, but the line is not marked valid. The flag clears on return to S_IDLE.
- Invalidate in the same cycle as req_i: invalidate wins, and the request is not granted that cycle.
- Counters saturate at 32'hFFFF_FFFF. If clr_cnt_i coincides with an increment, clr_cnt_i wins.

## Timing
- Reset: state S_IDLE, all valid=0, fill counter 0, sticky flag 0. Every output is 0 (gnt_o is combinationally 0 while state is reset).
- Reset mid-fill: the fill is abandoned, and no response is issued for the pending request.
- Hit latency is 1 cycle; back-to-back hits sustain one per cycle.
- Miss latency = Σ over LINE_WORDS of (grant wait + engine latency + 1) + 1 cycle. rvalid_o rises the cycle after the final eng_ready_i.
- eng_ready_i arriving in S_FILL_REQ is ignored.
- Requests are not granted while busy_o=1.

## Structure
- Package flash_xip_pkg holds:
  - the state enum (S_IDLE, S_FILL_REQ, S_FILL_WAIT);
  - functions for index/tag/offset widths derived from the parameters.
- Sub-module flash_xip_tag_array holds:
  - tag and valid storage;
  - combinational lookup;
  - single-cycle clear-all;
  - per-line set/clear.
- The data array and FSM stay in the top module.

## Test plan
- Reset, then read 0x000100 (defaults), engine returns 0xA0..0xA3 for 0x100..0x10C → one miss, four eng reads in address order, rvalid_o with data 0xA0. A repeat read of 0x000104 returns 0xA1 one cycle after grant; hit_cnt=1, miss_cnt=1.
- Read 0x000100 then 0x000900 (same index, different tag) → second is a miss and evicts the line. Re-reading 0x000100 misses again; miss_cnt=3.
- eng_error_i on the third fill word → rvalid_o with err_o=1 and data 0. A repeat read misses (line invalid).
- invalidate_i pulsed mid-fill → response delivered with correct data. The following read of the same address misses.
- Write request (we_i=1) → granted; next cycle rvalid_o=1, err_o=1; cache state and counters unchanged.
- Hold eng_gnt_i low 20 cycles during a fill → eng_addr_o stable, busy_o=1, and new req_i not granted. After 2^32−1 forced hits, hit_cnt_o saturates; clr_cnt_i zeroes it.
